// File: rtl/gmii_rx_deframer_if.sv
// ----------------------------------------------------------------------------
// gmii_rx_deframer_if
//
// Groups the SDR GMII receive stream and the deframed payload/status stream
// of gmii_rx_deframer into one bundle. rxclk and rstn are not carried here;
// they remain plain ports on the modules.
//
// Signals:
//   gmii_rxd    [7:0]      receive byte
//   gmii_rxdv              receive data valid
//   gmii_rxer              receive error
//   out_data    [7:0]      payload byte
//   out_valid              out_data valid this cycle
//   out_sof                first payload byte (qualified by out_valid)
//   out_eof                last payload byte (qualified by out_valid)
//   out_err                frame bad, meaningful only with out_eof
//   frame_ok               one-cycle pulse, frame passed all checks
//   frame_bad              one-cycle pulse, frame reached DATA and failed
//   cnt_good    [CNT_W-1:0] saturating good-frame count
//   cnt_bad     [CNT_W-1:0] saturating bad-frame count
//
// Modports:
//   slave  - the deframer: consumes GMII, produces payload and status
//   master - the environment: drives GMII, observes payload and status
// ----------------------------------------------------------------------------
interface gmii_rx_deframer_if #(
   parameter int CNT_W = 16
) ();

   logic [7:0]       gmii_rxd;
   logic             gmii_rxdv;
   logic             gmii_rxer;

   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_sof;
   logic             out_eof;
   logic             out_err;
   logic             frame_ok;
   logic             frame_bad;
   logic [CNT_W-1:0] cnt_good;
   logic [CNT_W-1:0] cnt_bad;

   modport slave (
      input  gmii_rxd, gmii_rxdv, gmii_rxer,
      output out_data, out_valid, out_sof, out_eof, out_err,
      output frame_ok, frame_bad, cnt_good, cnt_bad
   );

   modport master (
      output gmii_rxd, gmii_rxdv, gmii_rxer,
      input  out_data, out_valid, out_sof, out_eof, out_err,
      input  frame_ok, frame_bad, cnt_good, cnt_bad
   );

endinterface

// File: rtl/gmii_rx_deframer.sv
// ----------------------------------------------------------------------------
// gmii_rx_deframer
//
// Receives the SDR GMII byte stream (one byte per rxclk), strips preamble and
// SFD, checks the frame CRC-32 and length, and streams the payload out with
// start/end markers. The 4 FCS bytes are hidden by a 5-byte delay line: a
// byte is only released once five newer bytes have arrived, so when dv falls
// the bytes still held are exactly the last payload byte plus the FCS.
//
// Ports:
//   rxclk  - receive clock, all logic on its rising edge
//   rstn   - asynchronous active-low reset
//   bus    - gmii_rx_deframer_if.slave: GMII input, payload stream output,
//            frame_ok/frame_bad pulses and saturating good/bad counters
//
// Parameters:
//   MIN_LEN - minimum legal length after SFD, FCS included
//   MAX_LEN - maximum legal length after SFD, FCS included
//   CNT_W   - width of the good/bad frame counters
// ----------------------------------------------------------------------------
module gmii_rx_deframer #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int CNT_W   = 16
) (
   input  logic                  rxclk,
   input  logic                  rstn,
   gmii_rx_deframer_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE,
      PRE,
      DATA,
      DROP
   } state_t;

   localparam logic [7:0]  PRE_BYTE    = 8'h55;
   localparam logic [7:0]  SFD_BYTE    = 8'hD5;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
   // Register value left behind after shifting a frame and its own correct
   // FCS through this (MSB-first, LSB-first-bit-input) CRC formulation.
   localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
   localparam logic [15:0] MIN_L       = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L       = 16'(MAX_LEN);
   localparam logic [15:0] LEN_SAT     = 16'hFFFF;
   localparam logic [15:0] FILL_LEN    = 16'd5;
   localparam int          DL_DEPTH    = 5;

   // One byte of CRC-32. Data bits enter LSB first (Ethernet bit order)
   // into an MSB-first register, which is the bit-mirror of the usual
   // reflected shift-right form.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                              input logic [7:0]  d);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         fb = c[31] ^ d[i];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
      end
      return c;
   endfunction

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [15:0]      len_q, len_d;
   logic [31:0]      crc_q, crc_d;
   logic             err_q, err_d;
   logic [7:0]       dl_q [DL_DEPTH];   // [0] newest .. [4] oldest
   logic             shift_en;

   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_sof_q, out_sof_d;
   logic             out_eof_q, out_eof_d;
   logic             out_err_q, out_err_d;
   logic             frame_ok_q, frame_ok_d;
   logic             frame_bad_q, frame_bad_d;
   logic [CNT_W-1:0] cnt_good_q, cnt_bad_q;

   logic             frame_good;
   logic             have_fill;

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default here so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      len_d       = len_q;
      crc_d       = crc_q;
      err_d       = err_q;
      shift_en    = 1'b0;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
      out_err_d   = 1'b0;
      frame_ok_d  = 1'b0;
      frame_bad_d = 1'b0;

      // Evaluated on the first dv=0 cycle, when len_q/crc_q cover the whole
      // frame. Runts below 5 bytes fail here through the MIN_L test.
      frame_good = (crc_q == CRC_RESIDUE) && !err_q &&
                   (len_q >= MIN_L) && (len_q <= MAX_L);
      // Delay line holds five real bytes of this frame.
      have_fill  = (len_q >= FILL_LEN);

      unique case (state_q)
         IDLE: begin
            if (bus.gmii_rxdv) begin
               state_d = (bus.gmii_rxd == PRE_BYTE) ? PRE : DROP;
            end
         end

         PRE: begin
            if (!bus.gmii_rxdv) begin
               state_d = IDLE;
            end else if (bus.gmii_rxd == SFD_BYTE) begin
               state_d = DATA;
               len_d   = '0;
               crc_d   = CRC_INIT;
               err_d   = 1'b0;
            end else if (bus.gmii_rxd != PRE_BYTE) begin
               state_d = DROP;
            end
         end

         DATA: begin
            if (bus.gmii_rxdv) begin
               shift_en = 1'b1;
               crc_d    = crc32_byte(crc_q, bus.gmii_rxd);
               len_d    = (len_q == LEN_SAT) ? len_q : len_q + 16'd1;
               if (bus.gmii_rxer) begin
                  err_d = 1'b1;
               end
               if (have_fill) begin
                  out_valid_d = 1'b1;
                  out_data_d  = dl_q[DL_DEPTH-1];
                  out_sof_d   = (len_q == FILL_LEN);
               end
            end else begin
               // Frame end: the oldest held byte is the last payload byte,
               // the four newer ones are the FCS and are discarded.
               state_d = IDLE;
               if (have_fill) begin
                  out_valid_d = 1'b1;
                  out_data_d  = dl_q[DL_DEPTH-1];
                  out_sof_d   = (len_q == FILL_LEN);
                  out_eof_d   = 1'b1;
                  out_err_d   = !frame_good;
               end
               frame_ok_d  = frame_good;
               frame_bad_d = !frame_good;
            end
         end

         DROP: begin
            if (!bus.gmii_rxdv) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Control and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge rxclk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         len_q       <= '0;
         crc_q       <= CRC_INIT;
         err_q       <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         out_err_q   <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_bad_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q     <= state_d;
         len_q       <= len_d;
         crc_q       <= crc_d;
         err_q       <= err_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
         out_err_q   <= out_err_d;
         frame_ok_q  <= frame_ok_d;
         frame_bad_q <= frame_bad_d;
      end
   end

   // ------------------------------------------------------------------------
   // 5-byte delay line
   // ------------------------------------------------------------------------
   // NOTE: no reset on the delay line; its contents are only read once
   // len_q shows five bytes of the current frame have been written.
   always_ff @(posedge rxclk) begin
      if (shift_en) begin
         dl_q[0] <= bus.gmii_rxd;
         for (int i = 1; i < DL_DEPTH; i++) begin
            dl_q[i] <= dl_q[i-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Saturating frame counters, one cycle behind the status pulses
   // ------------------------------------------------------------------------
   always_ff @(posedge rxclk or negedge rstn) begin
      if (!rstn) begin
         cnt_good_q <= '0;
         cnt_bad_q  <= '0;
      end else begin
         if (frame_ok_q && (cnt_good_q != '1)) begin
            cnt_good_q <= cnt_good_q + CNT_W'(1);
         end
         if (frame_bad_q && (cnt_bad_q != '1)) begin
            cnt_bad_q <= cnt_bad_q + CNT_W'(1);
         end
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sof   = out_sof_q;
   assign bus.out_eof   = out_eof_q;
   assign bus.out_err   = out_err_q;
   assign bus.frame_ok  = frame_ok_q;
   assign bus.frame_bad = frame_bad_q;
   assign bus.cnt_good  = cnt_good_q;
   assign bus.cnt_bad   = cnt_bad_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// ----------------------------------------------------------------------------
// tb_gmii_rx_deframer
//
// Drives directed and randomized GMII frames into gmii_rx_deframer and
// compares the payload stream, status pulses and counters against a
// frame-level reference model: expected beats are derived from the byte list
// of each frame (payload = all but the last 4 bytes, byte k appears 6 cycles
// after it was driven), and frame validity from a software CRC-32 over the
// payload compared with the appended FCS, the rxer flags and the length.
// ----------------------------------------------------------------------------
module tb_gmii_rx_deframer;

   localparam int CNT_W   = 16;
   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;

   logic rxclk = 1'b0;
   logic rstn  = 1'b0;
   always #4 rxclk = ~rxclk;

   gmii_rx_deframer_if #(.CNT_W(CNT_W)) bus ();

   gmii_rx_deframer #(
      .MIN_LEN (MIN_LEN),
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .rxclk (rxclk),
      .rstn  (rstn),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] d;
      logic       sof;
      logic       eof;
      logic       err;
      int         cyc;
   } beat_t;

   typedef struct {
      logic ok;
      int   cyc;
   } pulse_t;

   int         vectors    = 0;
   int         miscompares = 0;
   int         cyc        = 0;
   int         exp_good   = 0;
   int         exp_bad    = 0;

   beat_t      obs_b[$];
   beat_t      exp_b[$];
   pulse_t     obs_p[$];
   pulse_t     exp_p[$];
   logic [7:0] frm[$];
   logic       fer[$];

   always @(posedge rxclk) cyc <= cyc + 1;

   // Monitor: record every payload beat and status pulse with its cycle.
   always @(negedge rxclk) begin
      beat_t  b;
      pulse_t p;
      if (rstn) begin
         if (bus.out_valid) begin
            b.d   = bus.out_data;
            b.sof = bus.out_sof;
            b.eof = bus.out_eof;
            b.err = bus.out_err;
            b.cyc = cyc;
            obs_b.push_back(b);
         end
         if (bus.frame_ok) begin
            p.ok = 1'b1; p.cyc = cyc; obs_p.push_back(p);
         end
         if (bus.frame_bad) begin
            p.ok = 1'b0; p.cyc = cyc; obs_p.push_back(p);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Standard reflected software CRC-32 over frm[0..n-1], final complement.
   function automatic logic [31:0] ref_crc32(input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int k = 0; k < n; k++) begin
         c ^= {24'h0, frm[k]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   task automatic build_raw(input int n);
      frm.delete(); fer.delete();
      for (int k = 0; k < n; k++) begin
         frm.push_back(8'($urandom));
         fer.push_back(1'b0);
      end
   endtask

   task automatic build_good(input int plen);
      logic [31:0] c;
      build_raw(plen);
      c = ref_crc32(plen);
      for (int k = 0; k < 4; k++) begin
         frm.push_back(c[8*k +: 8]);
         fer.push_back(1'b0);
      end
   endtask

   task automatic drv(input logic dv, input logic [7:0] d, input logic er);
      @(posedge rxclk);
      #1;
      bus.gmii_rxdv = dv;
      bus.gmii_rxd  = d;
      bus.gmii_rxer = er;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b0, 8'h00, 1'b0);
   endtask

   // Reference model for one frame of L bytes after SFD.
   task automatic model(input int t0, input int tend);
      int          len;
      logic        good;
      logic        any_er;
      logic [31:0] fcs;
      beat_t       b;
      pulse_t      p;
      len    = frm.size();
      any_er = 1'b0;
      foreach (fer[k]) any_er |= fer[k];
      good = (len >= MIN_LEN) && (len <= MAX_LEN) && !any_er;
      if (len >= 4) begin
         fcs  = {frm[len-1], frm[len-2], frm[len-3], frm[len-4]};
         good = good && (fcs == ref_crc32(len - 4));
      end else begin
         good = 1'b0;
      end
      for (int k = 0; k <= len - 5; k++) begin
         b.d   = frm[k];
         b.sof = (k == 0);
         b.eof = (k == len - 5);
         b.err = (k == len - 5) ? !good : 1'b0;
         b.cyc = t0 + k + 6;
         exp_b.push_back(b);
      end
      p.ok  = good;
      p.cyc = tend + 1;
      exp_p.push_back(p);
      if (good) exp_good++;
      else      exp_bad++;
   endtask

   // npre preamble bytes, SFD, frm/fer, then gap dv=0 cycles (gap >= 1).
   task automatic send(input int npre, input int gap);
      int t0;
      int tend;
      t0 = 0;
      repeat (npre) drv(1'b1, 8'h55, 1'b0);
      drv(1'b1, 8'hD5, 1'b0);
      for (int k = 0; k < frm.size(); k++) begin
         drv(1'b1, frm[k], fer[k]);
         if (k == 0) t0 = cyc;
      end
      drv(1'b0, 8'h00, 1'b0);
      tend = cyc;
      model(t0, tend);
      idle(gap - 1);
   endtask

   task automatic compare_all(input string tag);
      int n;
      n = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
      chk($sformatf("%s beat_count", tag), 64'(obs_b.size()), 64'(exp_b.size()));
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s beat%0d", tag, i),
             {21'h0, obs_b[i].d, obs_b[i].sof, obs_b[i].eof,
              obs_b[i].eof & obs_b[i].err, obs_b[i].cyc},
             {21'h0, exp_b[i].d, exp_b[i].sof, exp_b[i].eof,
              exp_b[i].eof & exp_b[i].err, exp_b[i].cyc});
      end
      n = (obs_p.size() < exp_p.size()) ? obs_p.size() : exp_p.size();
      chk($sformatf("%s pulse_count", tag), 64'(obs_p.size()), 64'(exp_p.size()));
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s pulse%0d", tag, i),
             {31'h0, obs_p[i].ok, obs_p[i].cyc}, {31'h0, exp_p[i].ok, exp_p[i].cyc});
      end
      chk($sformatf("%s cnt_good", tag), 64'(bus.cnt_good), 64'(exp_good));
      chk($sformatf("%s cnt_bad", tag), 64'(bus.cnt_bad), 64'(exp_bad));
      obs_b.delete(); exp_b.delete(); obs_p.delete(); exp_p.delete();
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk($sformatf("%s flags", tag),
          {57'h0, bus.out_valid, bus.out_sof, bus.out_eof, bus.out_err,
           bus.frame_ok, bus.frame_bad, 1'b0}, 64'h0);
      chk($sformatf("%s out_data", tag), 64'(bus.out_data), 64'h0);
      chk($sformatf("%s counters", tag), {32'h0, bus.cnt_good, bus.cnt_bad}, 64'h0);
   endtask

   initial begin
      int     t0;
      int     len;
      logic   clean;
      beat_t  b;

      bus.gmii_rxd  = 8'h00;
      bus.gmii_rxdv = 1'b0;
      bus.gmii_rxer = 1'b0;
      rstn          = 1'b0;

      // Reset state.
      @(negedge rxclk);
      chk_outputs_zero("reset");
      repeat (2) @(posedge rxclk);
      #1 rstn = 1'b1;
      idle(3);

      // Good 64-byte frame.
      build_good(60);
      send(7, 1);
      idle(4);
      compare_all("good64");

      // Last FCS byte corrupted.
      frm[63] = frm[63] ^ 8'h01;
      send(7, 1);
      idle(4);
      compare_all("bad_fcs");

      // rxer on payload byte 20 of an otherwise good frame.
      frm[63] = frm[63] ^ 8'h01;
      fer[20] = 1'b1;
      send(7, 1);
      idle(4);
      compare_all("rxer");

      // Runt of 10 bytes, then a 3-byte frame.
      build_raw(10);
      send(1, 2);
      build_raw(3);
      send(1, 1);
      idle(4);
      compare_all("runt");

      // Bad preamble: stays in DROP for the whole burst.
      drv(1'b1, 8'h55, 1'b0);
      drv(1'b1, 8'h12, 1'b0);
      repeat (68) drv(1'b1, 8'($urandom), 1'b0);
      idle(4);
      compare_all("bad_pre");

      // Two good frames separated by a single dv=0 cycle.
      build_good(60);
      send(7, 1);
      build_good(77);
      send(7, 1);
      idle(4);
      compare_all("b2b");

      // Length boundaries: one below minimum, maximum, one above maximum.
      build_good(59);
      send(7, 1);
      build_good(MAX_LEN - 4);
      send(7, 1);
      build_good(MAX_LEN - 3);
      send(7, 2);
      build_raw(5);
      send(3, 1);
      idle(4);
      compare_all("bounds");

      // Randomized short frames with optional corruption and rxer.
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(0, 90);
         if (len >= 4) build_good(len - 4);
         else          build_raw(len);
         if ((len > 0) && ($urandom_range(0, 3) == 0)) begin
            int i;
            i = $urandom_range(0, len - 1);
            frm[i] = frm[i] ^ 8'(1 << $urandom_range(0, 7));
         end
         if ((len > 0) && ($urandom_range(0, 3) == 0)) begin
            fer[$urandom_range(0, len - 1)] = 1'b1;
         end
         send($urandom_range(1, 7), $urandom_range(1, 3));
      end
      idle(4);
      compare_all("random");

      // Reset asserted while payload byte 30 of a good frame is on the wire.
      do begin
         build_good(60);
         clean = 1'b1;
         for (int k = 30; k < frm.size(); k++) if (frm[k] == 8'h55) clean = 1'b0;
      end while (!clean);
      repeat (7) drv(1'b1, 8'h55, 1'b0);
      drv(1'b1, 8'hD5, 1'b0);
      t0 = 0;
      for (int k = 0; k <= 30; k++) begin
         drv(1'b1, frm[k], 1'b0);
         if (k == 0) t0 = cyc;
      end
      #2 rstn = 1'b0;
      #1;
      chk_outputs_zero("mid_reset");
      // Beats seen before reset: byte k visible in cycle t0+k+6, up to t0+29.
      for (int k = 0; k <= 23; k++) begin
         b.d = frm[k]; b.sof = (k == 0); b.eof = 1'b0; b.err = 1'b0; b.cyc = t0 + k + 6;
         exp_b.push_back(b);
      end
      exp_good = 0;
      exp_bad  = 0;
      drv(1'b1, frm[31], 1'b0);
      rstn = 1'b1;
      for (int k = 32; k < frm.size(); k++) drv(1'b1, frm[k], 1'b0);
      idle(4);
      compare_all("reset_frame");

      build_good(60);
      send(7, 1);
      idle(4);
      compare_all("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
